// File: rtl/regfile_commit_sched.sv
// Commit-side write scheduler: buffers up to 4 retiring results per cycle in program order
// and drains up to 3 per cycle onto the register file write ports.

module regfile_commit_port #(
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          take,
   input  logic          keep,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   output logic          wen,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata
);
   always_ff @(posedge clk) begin
      if (reset) begin
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         wen <= take & keep;
         // idle ports keep their last address/data
         if (take) begin
            waddr <= addr;
            wdata <= data;
         end
      end
   end
endmodule

module regfile_commit_sched #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               in_valid,
   input  logic [4*AW-1:0]          in_waddr,
   input  logic [4*DW-1:0]          in_wdata,
   output logic                     in_ready,
   input  logic                     drain_en,
   output logic                     wen0,
   output logic                     wen1,
   output logic                     wen2,
   output logic [AW-1:0]            waddr0,
   output logic [AW-1:0]            waddr1,
   output logic [AW-1:0]            waddr2,
   output logic [DW-1:0]            wdata0,
   output logic [DW-1:0]            wdata1,
   output logic [DW-1:0]            wdata2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] RDY_MAX = (PW+1)'(DEPTH - 4);
   localparam logic [PW:0] CNT_1   = (PW+1)'(1);
   localparam logic [PW:0] CNT_2   = (PW+1)'(2);
   localparam logic [PW:0] CNT_3   = (PW+1)'(3);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t q [DEPTH];
   logic [PW-1:0] head, tail;

   logic [3:0][AW-1:0] la;
   logic [3:0][DW-1:0] ld;
   assign la = in_waddr;
   assign ld = in_wdata;

   assign in_ready = (count <= RDY_MAX);
   assign empty    = (count == '0);

   // compaction offsets: lane k lands at tail + (valid lanes older than k)
   logic [PW-1:0] ofs [4];
   logic [2:0]    enq_n;
   always_comb begin
      enq_n = '0;
      for (int k = 0; k < 4; k++) begin
         ofs[k] = PW'(enq_n);
         if (in_valid[k]) enq_n = enq_n + 3'd1;
      end
      if (!in_ready) enq_n = '0;
   end

   ent_t       g [3];
   logic [2:0] take, keep;
   logic [1:0] deq_n;
   always_comb begin
      for (int i = 0; i < 3; i++) g[i] = q[head + PW'(i)];
      take = 3'b000;
      if (drain_en) begin
         if (count >= CNT_3)      take = 3'b111;
         else if (count == CNT_2) take = 3'b011;
         else if (count == CNT_1) take = 3'b001;
      end
      deq_n = take[2] ? 2'd3 : take[1] ? 2'd2 : take[0] ? 2'd1 : 2'd0;
      // an older write is dropped when a younger one in the same group hits the same register
      keep[0] = !((take[1] && g[1].addr == g[0].addr) || (take[2] && g[2].addr == g[0].addr));
      keep[1] = !(take[2] && g[2].addr == g[1].addr);
      keep[2] = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (in_ready && in_valid[k]) q[tail + ofs[k]] <= ent_t'{addr: la[k], data: ld[k]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + PW'(enq_n);
         head  <= head + PW'(deq_n);
         count <= count + (PW+1)'(enq_n) - (PW+1)'(deq_n);
      end
   end

   logic [2:0]          wen_v;
   logic [2:0][AW-1:0]  wa_v;
   logic [2:0][DW-1:0]  wd_v;

   for (genvar p = 0; p < 3; p++) begin : g_port
      regfile_commit_port #(.AW(AW), .DW(DW)) u_port (
         .clk   (clk),
         .reset (reset),
         .take  (take[p]),
         .keep  (keep[p]),
         .addr  (g[p].addr),
         .data  (g[p].data),
         .wen   (wen_v[p]),
         .waddr (wa_v[p]),
         .wdata (wd_v[p])
      );
   end

   assign wen0 = wen_v[0];
   assign wen1 = wen_v[1];
   assign wen2 = wen_v[2];
   assign waddr0 = wa_v[0];
   assign waddr1 = wa_v[1];
   assign waddr2 = wa_v[2];
   assign wdata0 = wd_v[0];
   assign wdata1 = wd_v[1];
   assign wdata2 = wd_v[2];
endmodule
